// File: rtl/rr_fifo_scheduler.sv
// rr_fifo_scheduler: round-robin drain of four FWFT class FIFOs onto one
// shared output path. It has a per-queue burst limit and stalls while the
// downstream FIFO reports almost_full.
// Optional per-queue pop counters are included when RR_STATS_EN is defined.
module rr_fifo_scheduler #(
    parameter int DATA_W    = 10,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        fifo_empty,
    input  logic [DATA_W-1:0] data_in_0,
    input  logic [DATA_W-1:0] data_in_1,
    input  logic [DATA_W-1:0] data_in_2,
    input  logic [DATA_W-1:0] data_in_3,
    input  logic              almost_full,
    output logic [3:0]        pop,
    output logic [1:0]        select,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out
`ifdef RR_STATS_EN
    ,
    output logic [15:0]       word_cnt_0,
    output logic [15:0]       word_cnt_1,
    output logic [15:0]       word_cnt_2,
    output logic [15:0]       word_cnt_3
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [3:0] BURST_LIM = BURST_LEN[3:0];

    state_t            state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [1:0]        select_q, select_d;
    logic [3:0]        burst_cnt_q, burst_cnt_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              valid_out_q, valid_out_d;
    logic [3:0]        pop_s;
    logic [DATA_W-1:0] head_s;
    logic              found_s;
    logic [1:0]        grant_idx_s;
    logic [1:0]        cand_s;

    // Head word of the currently granted queue
    always_comb begin
        head_s = {DATA_W{1'b0}};
        case (select_q)
            2'd0:    head_s = data_in_0;
            2'd1:    head_s = data_in_1;
            2'd2:    head_s = data_in_2;
            2'd3:    head_s = data_in_3;
            default: head_s = {DATA_W{1'b0}};
        endcase
    end

    // First non-empty queue, searching upward from the round-robin pointer
    always_comb begin
        found_s     = 1'b0;
        grant_idx_s = 2'd0;
        cand_s      = 2'd0;
        for (int i = 0; i < 4; i++) begin
            cand_s = ptr_q + i[1:0];
            if (!found_s && !fifo_empty[cand_s]) begin
                found_s     = 1'b1;
                grant_idx_s = cand_s;
            end else begin
                found_s     = found_s;
                grant_idx_s = grant_idx_s;
            end
        end
    end

    // Next-state, pop strobe and output-register inputs
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        select_d    = select_q;
        burst_cnt_d = burst_cnt_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        pop_s       = 4'b0000;
        case (state_q)
            ST_IDLE: begin
                // A one-cycle arbitration bubble: no pop is issued from IDLE
                if (!almost_full && found_s) begin
                    select_d    = grant_idx_s;
                    burst_cnt_d = 4'd0;
                    state_d     = ST_GRANT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (almost_full) begin
                    // Stall: keep grant and burst credit untouched
                    state_d = ST_GRANT;
                end else if (fifo_empty[select_q]) begin
                    ptr_d   = select_q + 2'd1;
                    state_d = ST_IDLE;
                end else begin
                    pop_s[select_q] = 1'b1;
                    data_out_d      = head_s;
                    valid_out_d     = 1'b1;
                    burst_cnt_d     = burst_cnt_q + 4'd1;
                    if ((burst_cnt_q + 4'd1) == BURST_LIM) begin
                        ptr_d   = select_q + 2'd1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_GRANT;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Scheduler state and registered output path
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 2'd0;
            select_q    <= 2'd0;
            burst_cnt_q <= 4'd0;
            data_out_q  <= {DATA_W{1'b0}};
            valid_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            select_q    <= select_d;
            burst_cnt_q <= burst_cnt_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
        end
    end

    // Pop is forced low while reset is held
    assign pop       = pop_s & {4{reset}};
    assign select    = select_q;
    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;

`ifdef RR_STATS_EN
    logic [15:0] word_cnt_q [0:3];
    logic [15:0] word_cnt_d [0:3];

    // Per-queue pop counters, wrapping naturally at 0xFFFF
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            word_cnt_d[i] = word_cnt_q[i] + {15'd0, pop_s[i]};
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                word_cnt_q[i] <= 16'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                word_cnt_q[i] <= word_cnt_d[i];
            end
        end
    end

    assign word_cnt_0 = word_cnt_q[0];
    assign word_cnt_1 = word_cnt_q[1];
    assign word_cnt_2 = word_cnt_q[2];
    assign word_cnt_3 = word_cnt_q[3];
`endif

endmodule

// File: tb/tb_rr_fifo_scheduler.sv
// Directed testbench for rr_fifo_scheduler, with FWFT FIFO models on the
// input side. Checks are made on the falling clock edge.
module tb_rr_fifo_scheduler;

    logic       clk;
    logic       reset;
    logic [3:0] fifo_empty;
    logic [9:0] data_in_0, data_in_1, data_in_2, data_in_3;
    logic       almost_full;
    logic [3:0] pop;
    logic [1:0] select;
    logic [9:0] data_out;
    logic       valid_out;
`ifdef RR_STATS_EN
    logic [15:0] word_cnt_0, word_cnt_1, word_cnt_2, word_cnt_3;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    logic [9:0] q0[$];
    logic [9:0] q1[$];
    logic [9:0] q2[$];
    logic [9:0] q3[$];

    rr_fifo_scheduler #(.DATA_W(10), .BURST_LEN(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .fifo_empty  (fifo_empty),
        .data_in_0   (data_in_0),
        .data_in_1   (data_in_1),
        .data_in_2   (data_in_2),
        .data_in_3   (data_in_3),
        .almost_full (almost_full),
        .pop         (pop),
        .select      (select),
        .data_out    (data_out),
        .valid_out   (valid_out)
`ifdef RR_STATS_EN
        ,
        .word_cnt_0  (word_cnt_0),
        .word_cnt_1  (word_cnt_1),
        .word_cnt_2  (word_cnt_2),
        .word_cnt_3  (word_cnt_3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        fifo_empty[0] = (q0.size() == 0);
        fifo_empty[1] = (q1.size() == 0);
        fifo_empty[2] = (q2.size() == 0);
        fifo_empty[3] = (q3.size() == 0);
        data_in_0 = (q0.size() != 0) ? q0[0] : 10'h3FF;
        data_in_1 = (q1.size() != 0) ? q1[0] : 10'h3FF;
        data_in_2 = (q2.size() != 0) ? q2[0] : 10'h3FF;
        data_in_3 = (q3.size() != 0) ? q3[0] : 10'h3FF;
    endtask

    task automatic push(input int q, input logic [9:0] w);
        case (q)
            0:       q0.push_back(w);
            1:       q1.push_back(w);
            2:       q2.push_back(w);
            default: q3.push_back(w);
        endcase
        drive();
    endtask

    // One clock: sample pop, let the edge happen, retire popped heads, go to negedge
    task automatic step();
        logic [3:0] p;
        #1;
        p = pop;
        @(posedge clk);
        #1;
        if (p[0] && q0.size() != 0) void'(q0.pop_front());
        if (p[1] && q1.size() != 0) void'(q1.pop_front());
        if (p[2] && q2.size() != 0) void'(q2.pop_front());
        if (p[3] && q3.size() != 0) void'(q3.pop_front());
        drive();
        @(negedge clk);
    endtask

    function automatic logic [9:0] wd(input int q, input int j);
        return 10'((q << 8) | j);
    endfunction

    initial begin
        logic [9:0] prev;
        reset       = 1'b0;
        almost_full = 1'b0;
        prev        = 10'h000;
        for (int q = 0; q < 4; q++) begin
            for (int j = 0; j < 8; j++) begin
                push(q, wd(q, j));
            end
        end

        // Reset held with non-empty FIFOs
        @(negedge clk);
        chk("rst_pop", {28'd0, pop}, 32'h0);
        chk("rst_sel", {30'd0, select}, 32'h0);
        chk("rst_valid", {31'd0, valid_out}, 32'h0);
        chk("rst_data", {22'd0, data_out}, 32'h0);
        step();
        chk("rst_pop2", {28'd0, pop}, 32'h0);

        // Release: one IDLE bubble, then bursts of 4 in round-robin order
        reset = 1'b1;
        #1;
        chk("idle_bubble_pop", {28'd0, pop}, 32'h0);
        chk("idle_bubble_sel", {30'd0, select}, 32'h0);
        step();
        for (int b = 0; b < 8; b++) begin
            for (int k = 0; k < 4; k++) begin
                chk("rr_pop", {28'd0, pop}, 32'(4'b0001 << (b % 4)));
                chk("rr_sel", {30'd0, select}, 32'(b % 4));
                if (k == 0) begin
                    chk("rr_valid_first", {31'd0, valid_out}, 32'h0);
                end else begin
                    chk("rr_valid", {31'd0, valid_out}, 32'h1);
                    chk("rr_data", {22'd0, data_out}, {22'd0, prev});
                end
                prev = wd(b % 4, (b / 4) * 4 + k);
                step();
            end
            chk("gap_pop", {28'd0, pop}, 32'h0);
            chk("gap_valid", {31'd0, valid_out}, 32'h1);
            chk("gap_data", {22'd0, data_out}, {22'd0, prev});
            step();
        end
        chk("drained_pop", {28'd0, pop}, 32'h0);
        chk("drained_valid", {31'd0, valid_out}, 32'h0);

        // Only FIFO 2 holds two words; grant ends on empty and moves ptr to 3
        push(2, 10'h155);
        push(2, 10'h2AA);
        step();
        chk("q2_sel", {30'd0, select}, 32'h2);
        chk("q2_pop1", {28'd0, pop}, 32'h4);
        step();
        chk("q2_pop2", {28'd0, pop}, 32'h4);
        chk("q2_data1", {22'd0, data_out}, 32'h155);
        chk("q2_valid1", {31'd0, valid_out}, 32'h1);
        step();
        chk("q2_empty_pop", {28'd0, pop}, 32'h0);
        chk("q2_data2", {22'd0, data_out}, 32'h2AA);
        chk("q2_valid2", {31'd0, valid_out}, 32'h1);
        step();
        chk("q2_idle_valid", {31'd0, valid_out}, 32'h0);

        // Wrap: ptr is 3, queues 0 and 3 both non-empty -> q3 then q0
        push(0, 10'h011);
        push(3, 10'h033);
        step();
        chk("wrap_sel3", {30'd0, select}, 32'h3);
        chk("wrap_pop3", {28'd0, pop}, 32'h8);
        step();
        chk("wrap_data3", {22'd0, data_out}, 32'h033);
        chk("wrap_q3_empty_pop", {28'd0, pop}, 32'h0);
        step();
        chk("wrap_idle_pop", {28'd0, pop}, 32'h0);
        step();
        chk("wrap_sel0", {30'd0, select}, 32'h0);
        chk("wrap_pop0", {28'd0, pop}, 32'h1);
        step();
        chk("wrap_data0", {22'd0, data_out}, 32'h011);
        step();

        // Stall on almost_full for 3 cycles after the 2nd pop of a q1 burst
        for (int j = 0; j < 4; j++) begin
            push(1, 10'(10'h1A0 + j));
        end
        step();
        chk("af_sel", {30'd0, select}, 32'h1);
        chk("af_pop1", {28'd0, pop}, 32'h2);
        step();
        chk("af_pop2", {28'd0, pop}, 32'h2);
        chk("af_data1", {22'd0, data_out}, 32'h1A0);
        step();
        almost_full = 1'b1;
        #1;
        chk("af_stall_pop_a", {28'd0, pop}, 32'h0);
        chk("af_data2", {22'd0, data_out}, 32'h1A1);
        step();
        chk("af_stall_pop_b", {28'd0, pop}, 32'h0);
        chk("af_stall_valid_b", {31'd0, valid_out}, 32'h0);
        chk("af_stall_sel", {30'd0, select}, 32'h1);
        step();
        chk("af_stall_pop_c", {28'd0, pop}, 32'h0);
        chk("af_stall_valid_c", {31'd0, valid_out}, 32'h0);
        step();
        almost_full = 1'b0;
        #1;
        chk("af_resume_pop3", {28'd0, pop}, 32'h2);
        chk("af_resume_valid", {31'd0, valid_out}, 32'h0);
        step();
        chk("af_pop4", {28'd0, pop}, 32'h2);
        chk("af_data3", {22'd0, data_out}, 32'h1A2);
        step();
        chk("af_burst_end_pop", {28'd0, pop}, 32'h0);
        chk("af_data4", {22'd0, data_out}, 32'h1A3);
        chk("af_valid4", {31'd0, valid_out}, 32'h1);

        // Reset asserted mid-burst
        push(2, 10'h2C0);
        push(2, 10'h2C1);
        push(2, 10'h2C2);
        step();
        chk("mid_sel", {30'd0, select}, 32'h2);
        chk("mid_pop1", {28'd0, pop}, 32'h4);
        step();
        reset = 1'b0;
        #1;
        chk("mid_rst_pop", {28'd0, pop}, 32'h0);
        chk("mid_rst_sel", {30'd0, select}, 32'h0);
        chk("mid_rst_valid", {31'd0, valid_out}, 32'h0);
        chk("mid_rst_data", {22'd0, data_out}, 32'h0);
`ifdef RR_STATS_EN
        chk("stat_rst_1", {16'd0, word_cnt_1}, 32'h0);
        chk("stat_rst_2", {16'd0, word_cnt_2}, 32'h0);
`endif
        step();
        reset = 1'b1;
        step();
        chk("post_rst_sel", {30'd0, select}, 32'h2);
        chk("post_rst_pop", {28'd0, pop}, 32'h4);
        chk("post_rst_valid", {31'd0, valid_out}, 32'h0);
        step();
        step();
        chk("post_rst_data", {22'd0, data_out}, 32'h2C2);
        chk("post_rst_valid2", {31'd0, valid_out}, 32'h1);
`ifdef RR_STATS_EN
        chk("stat_cnt_0", {16'd0, word_cnt_0}, 32'h0);
        chk("stat_cnt_1", {16'd0, word_cnt_1}, 32'h0);
        chk("stat_cnt_2", {16'd0, word_cnt_2}, 32'h2);
        chk("stat_cnt_3", {16'd0, word_cnt_3}, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
